// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined add/subtract unit: operation encodings
// and small helpers that turn an opcode into the adder's B-invert control and
// carry-in, plus a configuration legality check used at elaboration.
// -----------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDC = 2'b10,
      OP_SUBB = 2'b11
   } addsub_op_e;

   // Subtraction is done as A + ~B + c, so both SUB flavours invert B.
   function automatic logic op_is_sub(input logic [1:0] op);
      return (addsub_op_e'(op) == OP_SUB) || (addsub_op_e'(op) == OP_SUBB);
   endfunction

   // Carry into bit 0: SUB supplies the +1 of two's complement, SUBB turns a
   // borrow-in into "no +1".
   function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
      logic c;
      case (addsub_op_e'(op))
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         OP_ADDC: c = cin;
         default: c = ~cin;
      endcase
      return c;
   endfunction

   function automatic bit legal_cfg(input int width, input int seg);
      return ((seg == 4) || (seg == 8) || (seg == 16)) &&
             (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/pipe_addsub_seg_cla.sv
// -----------------------------------------------------------------------------
// seg_cla
// SEG-bit carry-lookahead adder slice used by each pipeline stage.
//   x, y  : SEG-bit addends
//   cin   : carry into bit 0
//   sum   : SEG-bit sum
//   cout  : carry out of the top bit
// Every carry is formed directly from generate/propagate terms and cin, so no
// carry ripples through the slice.
// -----------------------------------------------------------------------------
module seg_cla #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   logic [SEG-1:0] g;
   logic [SEG-1:0] p;
   logic [SEG:0]   c;

   assign g = x & y;
   assign p = x ^ y;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built as a flat sum of products
   always_comb begin
      logic grp_g;
      logic grp_p;
      grp_g = 1'b0;
      grp_p = 1'b1;
      c     = '0;
      c[0]  = cin;
      for (int i = 0; i < SEG; i++) begin
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int j = i; j >= 0; j--) begin
            grp_g = grp_g | (g[j] & grp_p);
            grp_p = grp_p & p[j];
         end
         c[i+1] = grp_g | (grp_p & cin);
      end
   end

   assign sum  = p ^ c[SEG-1:0];
   assign cout = c[SEG];

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined WIDTH-bit adder/subtractor split into N = WIDTH/SEG stages. Stage k
// adds operand segment k with the carry registered by stage k-1. Operand
// segments not yet consumed ride down the pipe (skew) and finished result
// segments accumulate below the current one (de-skew), so the last stage holds
// the full result. All stages move together on en = ~out_valid | out_ready.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = en)
//   in_op               : 00 ADD, 01 SUB, 10 ADDC, 11 SUBB
//   in_a, in_b, in_cin  : operands, carry/borrow-in (ADDC/SUBB only)
//   in_tag              : returned unchanged with the result
//   flush               : drop everything in flight, accept nothing this cycle
//   out_valid/out_ready : output handshake
//   out_result          : A+B+c or A-B-b mod 2^WIDTH
//   out_cout            : carry (add) or borrow (sub)
//   out_ovf, out_zero, out_neg : signed overflow, zero, sign flags
//   out_tag             : tag of the completed operation
// -----------------------------------------------------------------------------
module pipe_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg,
   output logic [TAG_W-1:0] out_tag
);

   localparam int N = WIDTH / SEG;

   if (!legal_cfg(WIDTH, SEG)) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be a positive multiple of SEG and SEG one of 4, 8, 16");
   end

   logic             sub_in;
   logic [WIDTH-1:0] bx_in;
   logic             cx_in;
   logic             en;
   logic [N-1:0]     vld;

   assign sub_in = op_is_sub(in_op);
   assign bx_in  = sub_in ? ~in_b : in_b;
   assign cx_in  = op_carry_in(in_op, in_cin);

   assign en        = ~vld[N-1] | out_ready;
   assign in_ready  = en;
   assign out_valid = vld[N-1];

   // Flush discards in-flight work and also blocks the input of that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else if (flush) begin
         vld <= '0;
      end else if (en) begin
         vld[0] <= in_valid;
         for (int k = 1; k < N; k++) begin
            vld[k] <= vld[k-1];
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_stage
      logic [SEG-1:0]       x;
      logic [SEG-1:0]       y;
      logic [SEG-1:0]       s;
      logic                 ci;
      logic                 co;
      logic                 sub_s;
      logic                 src_v;
      logic [TAG_W-1:0]     tag_s;
      logic [SEG*(k+1)-1:0] res_n;

      if (k == 0) begin : g_src
         assign x     = in_a[SEG-1:0];
         assign y     = bx_in[SEG-1:0];
         assign ci    = cx_in;
         assign sub_s = sub_in;
         assign tag_s = in_tag;
         assign src_v = in_valid;
         assign res_n = s;
      end else begin : g_src
         assign x     = g_stage[k-1].g_hold.a_rem[SEG-1:0];
         assign y     = g_stage[k-1].g_hold.bx_rem[SEG-1:0];
         assign ci    = g_stage[k-1].g_hold.c_q;
         assign sub_s = g_stage[k-1].g_hold.sub_q;
         assign tag_s = g_stage[k-1].g_hold.tag_q;
         assign src_v = vld[k-1];
         assign res_n = {s, g_stage[k-1].g_hold.res_q};
      end

      seg_cla #(.SEG(SEG)) u_cla (
         .x    (x),
         .y    (y),
         .cin  (ci),
         .sum  (s),
         .cout (co)
      );

      if (k < N-1) begin : g_hold
         // RW: operand bits still waiting for later stages
         localparam int RW = WIDTH - SEG*(k+1);

         logic [RW-1:0]        a_rem;
         logic [RW-1:0]        bx_rem;
         logic [RW-1:0]        a_nxt;
         logic [RW-1:0]        bx_nxt;
         logic [SEG*(k+1)-1:0] res_q;
         logic                 c_q;
         logic                 sub_q;
         logic [TAG_W-1:0]     tag_q;

         if (k == 0) begin : g_fwd
            assign a_nxt  = in_a[WIDTH-1:SEG];
            assign bx_nxt = bx_in[WIDTH-1:SEG];
         end else begin : g_fwd
            assign a_nxt  = g_stage[k-1].g_hold.a_rem[RW+SEG-1:SEG];
            assign bx_nxt = g_stage[k-1].g_hold.bx_rem[RW+SEG-1:SEG];
         end

         // Datapath needs no reset: vld qualifies everything downstream.
         always_ff @(posedge clk) begin
            if (en && src_v) begin
               a_rem  <= a_nxt;
               bx_rem <= bx_nxt;
               res_q  <= res_n;
               c_q    <= co;
               sub_q  <= sub_s;
               tag_q  <= tag_s;
            end
         end
      end else begin : g_out
         // Top segment carries A and Bx sign bits, so overflow is judged here.
         always_ff @(posedge clk) begin
            if (rst) begin
               out_result <= '0;
               out_cout   <= 1'b0;
               out_ovf    <= 1'b0;
               out_zero   <= 1'b0;
               out_neg    <= 1'b0;
               out_tag    <= '0;
            end else if (en && src_v && !flush) begin
               out_result <= res_n;
               out_cout   <= co ^ sub_s;
               out_ovf    <= (x[SEG-1] == y[SEG-1]) && (s[SEG-1] != x[SEG-1]);
               out_zero   <= (res_n == '0);
               out_neg    <= s[SEG-1];
               out_tag    <= tag_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_addsub.sv
module tb_pipe_addsub;
   import addsub_pkg::*;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
      logic [3:0]  tag;
      int          acc_cyc;
      bit          lat_chk;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_cin;
   logic [3:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_cout;
   logic        out_ovf;
   logic        out_zero;
   logic        out_neg;
   logic [3:0]  out_tag;

   pipe_addsub #(.WIDTH(32), .SEG(8), .TAG_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_cin     (in_cin),
      .in_tag     (in_tag),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_ovf    (out_ovf),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_tag    (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   n_out = 0;
   int   n_stall = 0;
   int   stall_left = 0;
   bit   rnd_ready = 0;
   exp_t q[$];
   exp_t nxt;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
   endtask

   // Reference: plain wide arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic [3:0] tag);
      exp_t        e;
      logic [32:0] full;
      longint      sr;
      longint      c;
      c = ((op == OP_ADDC || op == OP_SUBB) && cin) ? 64'sd1 : 64'sd0;
      if (op == OP_ADD || op == OP_ADDC) begin
         full = {1'b0, a} + {1'b0, b} + 33'(c);
         sr   = longint'($signed(a)) + longint'($signed(b)) + c;
      end else begin
         full = {1'b0, a} - {1'b0, b} - 33'(c);
         sr   = longint'($signed(a)) - longint'($signed(b)) - c;
      end
      e.res     = full[31:0];
      e.cout    = full[32];
      e.ovf     = (sr > SMAX) || (sr < SMIN);
      e.zero    = (full[31:0] == 32'd0);
      e.neg     = full[31];
      e.tag     = tag;
      e.acc_cyc = 0;
      e.lat_chk = 1'b1;
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] res, input logic cout, input logic ovf,
                               input logic zero, input logic neg, input logic [3:0] tag);
      exp_t e;
      e.res = res; e.cout = cout; e.ovf = ovf; e.zero = zero; e.neg = neg; e.tag = tag;
      e.acc_cyc = 0;
      e.lat_chk = 1'b1;
      return e;
   endfunction

   // One clock: sample just after the negedge where inputs were set, then advance.
   task automatic tick(output bit acc);
      exp_t e;
      acc = 1'b0;
      #1;
      cyc++;
      if (rst || flush) begin
         q.delete();
      end else begin
         chk("no_spurious_out", 64'(out_valid && (q.size() == 0)), 64'd0);
         if (out_valid && q.size() > 0) begin
            if (out_ready) begin
               e = q.pop_front();
               n_out++;
               chk("result", 64'(out_result), 64'(e.res));
               chk("cout",   64'(out_cout),   64'(e.cout));
               chk("ovf",    64'(out_ovf),    64'(e.ovf));
               chk("zero",   64'(out_zero),   64'(e.zero));
               chk("neg",    64'(out_neg),    64'(e.neg));
               chk("tag",    64'(out_tag),    64'(e.tag));
               if (e.lat_chk) chk("latency", 64'(cyc - e.acc_cyc), 64'd4);
            end else begin
               n_stall++;
               chk("stall_in_ready", 64'(in_ready), 64'd0);
               chk("stall_hold_result", 64'(out_result), 64'(q[0].res));
               chk("stall_hold_tag", 64'(out_tag), 64'(q[0].tag));
               foreach (q[i]) q[i].lat_chk = 1'b0;
            end
         end
         if (in_valid && in_ready) begin
            acc = 1'b1;
            e = nxt;
            e.acc_cyc = cyc;
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ready();
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else if (rnd_ready) begin
         out_ready = ($urandom_range(0, 3) != 0);
      end else begin
         out_ready = 1'b1;
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] tag, input exp_t e);
      bit acc;
      int n;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; in_tag = tag;
      nxt = e;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 30) begin
         set_ready();
         tick(acc);
         n++;
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [3:0] tag);
      send(op, a, b, cin, tag, model(op, a, b, cin, tag));
   endtask

   task automatic idle(input int k);
      bit acc;
      in_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
         set_ready();
         tick(acc);
      end
   endtask

   task automatic drain();
      bit acc;
      int n;
      in_valid = 1'b0;
      n = 0;
      while (q.size() > 0 && n < 60) begin
         set_ready();
         tick(acc);
         n++;
      end
      if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   task automatic check_reset_state(input string where);
      chk({where, "_out_valid"},  64'(out_valid),  64'd0);
      chk({where, "_out_result"}, 64'(out_result), 64'd0);
      chk({where, "_out_cout"},   64'(out_cout),   64'd0);
      chk({where, "_out_ovf"},    64'(out_ovf),    64'd0);
      chk({where, "_out_zero"},   64'(out_zero),   64'd0);
      chk({where, "_out_neg"},    64'(out_neg),    64'd0);
      chk({where, "_out_tag"},    64'(out_tag),    64'd0);
      chk({where, "_in_ready"},   64'(in_ready),   64'd1);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit acc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0; out_ready = 1'b1;
      @(negedge clk);
      tick(acc);
      tick(acc);
      rst = 1'b0;
      check_reset_state("reset");

      // Directed corner vectors, one at a time with out_ready high
      send(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h1, mk(32'h0000_0000, 1, 0, 1, 0, 4'h1));
      drain();
      send(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h2, mk(32'h8000_0000, 0, 1, 0, 1, 4'h2));
      drain();
      send(OP_SUB,  32'h0000_0005, 32'h0000_0007, 1'b0, 4'h3, mk(32'hFFFF_FFFE, 1, 0, 0, 1, 4'h3));
      drain();
      send(OP_SUBB, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'h4, mk(32'hFFFF_FFFF, 1, 0, 0, 1, 4'h4));
      drain();
      send(OP_ADDC, 32'h0000_00FF, 32'h0000_0001, 1'b1, 4'h5, mk(32'h0000_0101, 0, 0, 0, 0, 4'h5));
      drain();

      // 8 back-to-back ops, output stalled 3 cycles mid-stream
      n_out = 0;
      n_stall = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 5) stall_left = 3;
         send_m(2'(i % 4), 32'h0100_0000 * i + 32'h00FF_FF00, 32'h0000_0100 + i, 1'(i % 2), 4'(i));
      end
      drain();
      chk("stream_results_returned", 64'(n_out), 64'd8);
      chk("stream_stall_cycles", 64'(n_stall), 64'd3);

      // Flush with 3 ops in flight; the flush-cycle input must be ignored
      for (int i = 0; i < 3; i++) send_m(OP_ADD, 32'h1000 + i, 32'h1, 1'b0, 4'(8 + i));
      flush = 1'b1;
      in_valid = 1'b1; in_op = OP_SUB; in_a = 32'h55; in_b = 32'h11; in_tag = 4'hB;
      set_ready();
      tick(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      idle(8);
      send(OP_ADD, 32'h0000_1234, 32'h0000_4321, 1'b0, 4'hC, mk(32'h0000_5555, 0, 0, 0, 0, 4'hC));
      drain();

      // Reset mid-stream
      for (int i = 0; i < 3; i++) send_m(OP_SUB, 32'h9000_0000, 32'h1 + i, 1'b0, 4'(i));
      rst = 1'b1;
      in_valid = 1'b1;
      tick(acc);
      rst = 1'b0;
      in_valid = 1'b0;
      check_reset_state("midrst");
      idle(8);
      send_m(OP_SUBB, 32'h8000_0000, 32'h0000_0001, 1'b1, 4'hD);
      drain();

      // Randomized traffic with random backpressure and idle gaps
      rnd_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send_m(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
                1'($urandom_range(0, 1)), 4'(i));
      end
      drain();
      rnd_ready = 1'b0;
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
